// File: rtl/cam_cfg_pkg.sv
// ============================================================================
// cam_cfg_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the camera register-init sequencer.
//   cfg_entry_t : one table entry, {register address, register value}
//   CFG_END     : entry value that terminates a table
//   CFG_DELAY   : entry value that inserts a fixed settle delay
//   state_t     : sequencer FSM states
//   mkEntry     : helper that builds a write entry from address and value
// ============================================================================
package cam_cfg_pkg;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } cfg_entry_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT,
        DELAY,
        DONE,
        ERR
    } state_t;

    // Builds a register write entry so the ROM tables read as address/value pairs.
    function automatic cfg_entry_t mkEntry(input logic [7:0] addr, input logic [7:0] data);
        return '{reg_addr: addr, reg_data: data};
    endfunction

endpackage

// File: rtl/cam_cfg_table.sv
// ============================================================================
// cam_cfg_table
// ----------------------------------------------------------------------------
// Synchronous case-ROM holding one register-init table per sensor mode.
// The entry addressed by (mode_i, idx_i) appears on entry_o one clock later.
// Any address outside a table, outside DEPTH or outside N_MODES reads as the
// end marker, so a table without an explicit end still terminates cleanly.
//
// Ports
//   clk_i    in   1       system clock
//   mode_i   in   MW      table select
//   idx_i    in   AW      entry index within the table
//   entry_o  out  16      registered table entry (cfg_entry_t)
// ============================================================================
module cam_cfg_table
    import cam_cfg_pkg::*;
#(
    parameter int N_MODES = 2,
    parameter int DEPTH   = 256,
    parameter int MW      = 1,
    parameter int AW      = 8
) (
    input  logic          clk_i,
    input  logic [MW-1:0] mode_i,
    input  logic [AW-1:0] idx_i,
    output cfg_entry_t    entry_o
);

    cfg_entry_t entry_d;
    cfg_entry_t entry_q;

    // Table lookup. Mode 0 is QVGA RGB565: soft-reset the sensor through
    // COM7, let it settle, then select QVGA + RGB. Mode 1 is VGA YUV422 and
    // carries no explicit end marker; the first index past its last write
    // falls through to the default and terminates the walk.
    always_comb begin
        entry_d = cfg_entry_t'(CFG_END);
        case (int'(mode_i))
            0: begin
                case (int'(idx_i))
                    0:       entry_d = mkEntry(8'h12, 8'h80);
                    1:       entry_d = cfg_entry_t'(CFG_DELAY);
                    2:       entry_d = mkEntry(8'h12, 8'h14);
                    3:       entry_d = cfg_entry_t'(CFG_END);
                    default: entry_d = cfg_entry_t'(CFG_END);
                endcase
            end
            1: begin
                case (int'(idx_i))
                    0:       entry_d = mkEntry(8'h11, 8'h80);
                    1:       entry_d = mkEntry(8'h12, 8'h00);
                    2:       entry_d = mkEntry(8'h0C, 8'h04);
                    3:       entry_d = mkEntry(8'h3E, 8'h00);
                    4:       entry_d = mkEntry(8'h40, 8'hC0);
                    5:       entry_d = mkEntry(8'h3A, 8'h04);
                    6:       entry_d = mkEntry(8'h67, 8'h80);
                    7:       entry_d = mkEntry(8'h68, 8'h80);
                    default: entry_d = cfg_entry_t'(CFG_END);
                endcase
            end
            default: entry_d = cfg_entry_t'(CFG_END);
        endcase

        // Guards for non-power-of-two DEPTH and for modes beyond the table set.
        if (int'(idx_i) >= DEPTH) begin
            entry_d = cfg_entry_t'(CFG_END);
        end
        if (int'(mode_i) >= N_MODES) begin
            entry_d = cfg_entry_t'(CFG_END);
        end
    end

    // One-cycle read latency, matching a block-RAM style ROM.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// ============================================================================
// cam_cfg_sequencer
// ----------------------------------------------------------------------------
// Walks the register-init table selected by `mode` and hands every write
// entry to the SCCB write master over a valid/ready handshake. Delay markers
// stall for DELAY_CYC clocks, end markers (or the last table index) finish the
// sequence, and NACKed writes are re-issued up to MAX_RETRY times before the
// sequencer gives up with error.
//
// Ports
//   clk        in   1    system clock
//   reset      in   1    synchronous, active-high
//   start      in   1    one-cycle pulse, honoured only when not busy
//   mode       in   MW   table select, sampled on start
//   cmd_valid  out  1    write request to the SCCB master
//   cmd_ready  in   1    master accepts when cmd_valid && cmd_ready
//   cmd_reg    out  8    register address of the pending write
//   cmd_data   out  8    register value of the pending write
//   wr_done    in   1    one-cycle pulse, write finished
//   wr_nack    in   1    qualifies wr_done: slave NACKed
//   busy       out  1    sequence in progress
//   done       out  1    level, table completed
//   error      out  1    level, retries exhausted or mode out of range
//   entry_idx  out  AW   index of the entry being processed, held afterwards
// ============================================================================
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int  N_MODES   = 2,
    parameter int  DEPTH     = 256,
    parameter int  DELAY_CYC = 2500000,
    parameter int  MAX_RETRY = 3,
    localparam int MW        = (N_MODES > 1) ? $clog2(N_MODES) : 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [MW-1:0] mode,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_reg,
    output logic [7:0]    cmd_data,
    input  logic          wr_done,
    input  logic          wr_nack,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] entry_idx
);

    localparam int DCW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [AW-1:0]  LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [DCW-1:0] DELAY_LOAD = DCW'(DELAY_CYC - 1);
    localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRY);

    state_t          state_q,    state_d;
    logic [MW-1:0]   modeSel_q,  modeSel_d;
    logic [AW-1:0]   idx_q,      idx_d;
    logic [RCW-1:0]  retryCnt_q, retryCnt_d;
    logic [DCW-1:0]  delayCnt_q, delayCnt_d;
    logic            cmdValid_q, cmdValid_d;
    logic [7:0]      cmdReg_q,   cmdReg_d;
    logic [7:0]      cmdData_q,  cmdData_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            error_q,    error_d;

    logic            entryDone;
    logic            tableDone;
    cfg_entry_t      romEntry;
    logic [15:0]     romWord;

    // The ROM is addressed from registered state only, so the latched mode
    // decides the table and a wiggling mode input cannot disturb a running walk.
    cam_cfg_table #(
        .N_MODES (N_MODES),
        .DEPTH   (DEPTH),
        .MW      (MW),
        .AW      (AW)
    ) u_table (
        .clk_i   (clk),
        .mode_i  (modeSel_q),
        .idx_i   (idx_q),
        .entry_o (romEntry)
    );

    assign romWord = romEntry;

    // Next-state logic. entryDone marks an entry that finished (write acked or
    // delay elapsed); tableDone marks the end of the whole walk. Both are
    // resolved after the state case so the last-index check lives in one place.
    always_comb begin
        state_d    = state_q;
        modeSel_d  = modeSel_q;
        idx_d      = idx_q;
        retryCnt_d = retryCnt_q;
        delayCnt_d = delayCnt_q;
        cmdValid_d = cmdValid_q;
        cmdReg_d   = cmdReg_q;
        cmdData_d  = cmdData_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        entryDone  = 1'b0;
        tableDone  = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    modeSel_d  = mode;
                    idx_d      = '0;
                    retryCnt_d = '0;
                    delayCnt_d = '0;
                    done_d     = 1'b0;
                    if (int'(mode) >= N_MODES) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end

            FETCH: begin
                state_d = DECODE;
            end

            DECODE: begin
                if (romWord == CFG_END) begin
                    tableDone = 1'b1;
                end else if (romWord == CFG_DELAY) begin
                    state_d    = DELAY;
                    delayCnt_d = DELAY_LOAD;
                end else begin
                    state_d    = ISSUE;
                    cmdReg_d   = romEntry.reg_addr;
                    cmdData_d  = romEntry.reg_data;
                    cmdValid_d = 1'b1;
                    retryCnt_d = '0;
                end
            end

            ISSUE: begin
                if (cmdValid_q && cmd_ready) begin
                    cmdValid_d = 1'b0;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        entryDone = 1'b1;
                    end else if (retryCnt_q < RETRY_MAX) begin
                        retryCnt_d = retryCnt_q + 1'b1;
                        cmdValid_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            DELAY: begin
                if (delayCnt_q == '0) begin
                    entryDone = 1'b1;
                end else begin
                    delayCnt_d = delayCnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The last index finishes the table instead of wrapping back to 0.
        if (entryDone) begin
            if (idx_q == LAST_IDX) begin
                tableDone = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
            end
        end

        if (tableDone) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end
    end

    // State and handshake registers. Reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            modeSel_q  <= '0;
            idx_q      <= '0;
            retryCnt_q <= '0;
            delayCnt_q <= '0;
            cmdValid_q <= 1'b0;
            cmdReg_q   <= '0;
            cmdData_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            modeSel_q  <= modeSel_d;
            idx_q      <= idx_d;
            retryCnt_q <= retryCnt_d;
            delayCnt_q <= delayCnt_d;
            cmdValid_q <= cmdValid_d;
            cmdReg_q   <= cmdReg_d;
            cmdData_q  <= cmdData_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign cmd_valid = cmdValid_q;
    assign cmd_reg   = cmdReg_q;
    assign cmd_data  = cmdData_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign entry_idx = idx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// ============================================================================
// tb_cam_cfg_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for cam_cfg_sequencer with a small SCCB master model
// (ready three cycles after valid, write done twenty cycles after accept) and
// a scoreboard of expected {reg, data} writes.
// ============================================================================
module tb_cam_cfg_sequencer;

    localparam int N_MODES   = 3;
    localparam int DEPTH     = 8;
    localparam int DELAY_CYC = 16;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  entry_idx;

    int checks = 0;
    int errors = 0;

    logic [15:0] expQ[$];

    int phase       = 0;
    int waitCnt     = 0;
    int busyCnt     = 0;
    int readyDelay  = 3;
    int nackLeft    = 0;
    int acceptCount = 0;
    int validRises  = 0;
    int doneEvents  = 0;
    int cyc         = 0;
    int lastDoneCyc = 0;
    int lastGap     = 0;
    int base        = 0;
    int riseBase    = 0;

    logic [15:0] mode1Writes [8] = '{16'h1180, 16'h1200, 16'h0C04, 16'h3E00,
                                     16'h40C0, 16'h3A04, 16'h6780, 16'h6880};

    cam_cfg_sequencer #(
        .N_MODES   (N_MODES),
        .DEPTH     (DEPTH),
        .DELAY_CYC (DELAY_CYC),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic waitFinish(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done || error) break;
            @(negedge clk);
        end
        checkOutput(tag, 32'(done | error), 32'd1);
    endtask

    task automatic waitAccepts(input string tag, input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (acceptCount >= target) break;
            @(negedge clk);
        end
        checkOutput(tag, 32'(acceptCount >= target), 32'd1);
    endtask

    task automatic waitDoneEvents(input string tag, input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (doneEvents >= target) break;
            @(negedge clk);
        end
        checkOutput(tag, 32'(doneEvents >= target), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({cmd_valid, busy, done, error}), 32'd0);
        checkOutput({tag, "_cmd"}, 32'({cmd_reg, cmd_data}), 32'd0);
        checkOutput({tag, "_idx"}, 32'(entry_idx), 32'd0);
    endtask

    task automatic pushMode0;
        expQ.push_back(16'h1280);
        expQ.push_back(16'h1214);
    endtask

    task automatic pushMode1;
        for (int i = 0; i < 8; i++) expQ.push_back(mode1Writes[i]);
    endtask

    // SCCB master model: evaluated on the falling edge so DUT outputs are
    // stable and responses are set up well before the next rising edge.
    always @(negedge clk) begin
        cyc++;
        cmd_ready = 1'b0;
        wr_done   = 1'b0;
        wr_nack   = 1'b0;
        if (reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (cmd_valid) begin
                        lastGap = cyc - lastDoneCyc;
                        validRises++;
                        waitCnt = 1;
                        phase   = 1;
                    end
                end
                1: begin
                    checkOutput("hold_valid", 32'(cmd_valid), 32'd1);
                    if (expQ.size() > 0) begin
                        checkOutput("hold_word", 32'({cmd_reg, cmd_data}), 32'(expQ[0]));
                    end
                    waitCnt++;
                    if (waitCnt >= readyDelay) begin
                        cmd_ready = 1'b1;
                        acceptCount++;
                        checkOutput("sb_avail", 32'(expQ.size() > 0), 32'd1);
                        if (expQ.size() > 0) begin
                            checkOutput("sb_write", 32'({cmd_reg, cmd_data}), 32'(expQ.pop_front()));
                        end
                        busyCnt = 0;
                        phase   = 2;
                    end
                end
                default: begin
                    busyCnt++;
                    if (busyCnt == 1) begin
                        checkOutput("valid_drop", 32'(cmd_valid), 32'd0);
                    end
                    if (busyCnt >= 20) begin
                        wr_done = 1'b1;
                        wr_nack = (nackLeft > 0);
                        if (nackLeft > 0) nackLeft--;
                        lastDoneCyc = cyc;
                        doneEvents++;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    // Directed sequence: reset, each table, retries, errors, resets mid-run.
    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        waitCycles(3);
        checkResetState("reset");
        reset = 1'b0;

        $display("[TB] T1 mode 0 table with delay");
        pushMode0();
        base = acceptCount;
        applyStimulus(2'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        waitFinish("t1_finish", 400);
        checkOutput("t1_ctrl", 32'({busy, done, error}), 32'b010);
        checkOutput("t1_idx", 32'(entry_idx), 32'd3);
        checkOutput("t1_accepts", 32'(acceptCount - base), 32'd2);
        checkOutput("t1_delay_gap", 32'(lastGap), 32'd21);
        checkOutput("t1_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] T2/T6 ready held off, rerun after done");
        readyDelay = 10;
        pushMode0();
        base     = acceptCount;
        riseBase = validRises;
        applyStimulus(2'd0);
        checkOutput("t6_done_clr", 32'({busy, done}), 32'b10);
        waitFinish("t2_finish", 500);
        checkOutput("t2_done", 32'({busy, done, error}), 32'b010);
        checkOutput("t2_accepts", 32'(acceptCount - base), 32'd2);
        checkOutput("t2_valid_rises", 32'(validRises - riseBase), 32'd2);
        readyDelay = 3;

        $display("[TB] T3 NACK twice then success");
        nackLeft = 2;
        expQ.push_back(16'h1180);
        expQ.push_back(16'h1180);
        pushMode1();
        base = acceptCount;
        applyStimulus(2'd1);
        waitFinish("t3_finish", 1500);
        checkOutput("t3_ctrl", 32'({busy, done, error}), 32'b010);
        checkOutput("t3_idx", 32'(entry_idx), 32'd7);
        checkOutput("t3_accepts", 32'(acceptCount - base), 32'd10);
        checkOutput("t3_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] T3 NACK every attempt");
        nackLeft = 100;
        expQ.push_back(16'h1180);
        expQ.push_back(16'h1180);
        expQ.push_back(16'h1180);
        base = acceptCount;
        applyStimulus(2'd1);
        waitFinish("t3n_finish", 500);
        checkOutput("t3n_ctrl", 32'({busy, done, error}), 32'b001);
        checkOutput("t3n_accepts", 32'(acceptCount - base), 32'd3);
        checkOutput("t3n_idx", 32'(entry_idx), 32'd0);
        riseBase = validRises;
        waitCycles(30);
        checkOutput("t3n_no_reissue", 32'(validRises - riseBase), 32'd0);
        nackLeft = 0;

        $display("[TB] T4/T6 mode 1 full table, start while busy");
        pushMode1();
        base = acceptCount;
        applyStimulus(2'd1);
        waitAccepts("t6_reach", base + 2, 200);
        applyStimulus(2'd0);
        checkOutput("t6_busy_ignore", 32'({busy, done, error}), 32'b100);
        waitFinish("t4_finish", 1000);
        checkOutput("t4_ctrl", 32'({busy, done, error}), 32'b010);
        checkOutput("t4_idx", 32'(entry_idx), 32'd7);
        checkOutput("t4_accepts", 32'(acceptCount - base), 32'd8);
        checkOutput("t4_min_gap", 32'(lastGap), 32'd3);
        checkOutput("t4_sb_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] T4 mode out of range");
        riseBase = validRises;
        applyStimulus(2'd3);
        checkOutput("t4m_ctrl", 32'({cmd_valid, busy, done, error}), 32'b0001);
        waitCycles(10);
        checkOutput("t4m_no_valid", 32'(validRises - riseBase), 32'd0);

        $display("[TB] T5 reset during WAIT");
        pushMode0();
        base = acceptCount;
        applyStimulus(2'd0);
        waitAccepts("t5w_reach", base + 1, 100);
        waitCycles(5);
        checkOutput("t5w_in_wait", 32'({cmd_valid, busy}), 32'b01);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("t5w_reset");
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        pushMode0();
        base = acceptCount;
        applyStimulus(2'd0);
        waitFinish("t5w_finish", 400);
        checkOutput("t5w_ctrl", 32'({busy, done, error}), 32'b010);
        checkOutput("t5w_accepts", 32'(acceptCount - base), 32'd2);

        $display("[TB] T5 reset during DELAY");
        pushMode0();
        base = doneEvents;
        applyStimulus(2'd0);
        waitDoneEvents("t5d_reach", base + 1, 100);
        waitCycles(6);
        checkOutput("t5d_in_delay", 32'({cmd_valid, busy, entry_idx}), 32'b0_1_001);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("t5d_reset");
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        pushMode0();
        base = acceptCount;
        applyStimulus(2'd0);
        waitFinish("t5d_finish", 400);
        checkOutput("t5d_ctrl", 32'({busy, done, error}), 32'b010);
        checkOutput("t5d_accepts", 32'(acceptCount - base), 32'd2);
        checkOutput("t5d_idx", 32'(entry_idx), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
